// File: rtl/ssd_scan_controller_if.sv
// Load handshake between a display-value producer and the scan controller.
interface ssd_scan_controller_if;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/ssd_scan_controller.sv
// Four-digit seven-segment scan sequencer with blanking between digits and
// frame-synchronous, tear-free commit of newly loaded display values.
module ssd_scan_controller #(
   parameter int DIV          = 50000,
   parameter int BLANK_CYCLES = 64,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   ssd_scan_controller_if.slave load_if,
   output logic [15:0]          disp_value,
   output logic                 S0,
   output logic                 S1,
   output logic [3:0]           AN,
   output logic                 frame_done
);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_SHOW_LAST  = CNT_W'(DIV - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_digit;
   logic [3:0]       r_an;
   logic             r_frame_done;
   logic [15:0]      r_disp;
   logic [15:0]      r_pend_data;
   logic             r_pending;
   logic             r_ready;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       w_digit_nxt;
   logic [3:0]       w_an_nxt;
   logic             w_wrap;
   logic             w_capture;
   logic             w_commit;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_digit_nxt = r_digit;
      w_wrap      = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_cnt_nxt   = '0;
            w_digit_nxt = 2'd0;
            if (enable) w_state_nxt = BLANK;
         end
         BLANK: begin
            if (!enable) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_digit_nxt = 2'd0;
            end else if (r_cnt == C_BLANK_LAST) begin
               w_state_nxt = SHOW;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         SHOW: begin
            if (!enable) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_digit_nxt = 2'd0;
            end else if (r_cnt == C_SHOW_LAST) begin
               w_state_nxt = BLANK;
               w_cnt_nxt   = '0;
               w_digit_nxt = r_digit + 2'd1;
               w_wrap      = (r_digit == 2'd3);
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      w_an_nxt  = (w_state_nxt == SHOW) ? ~(4'b0001 << w_digit_nxt) : 4'b1111;
      w_capture = load_if.load_valid && r_ready;
      // Idle display has no frame to tear, so a pending value commits immediately.
      w_commit  = r_pending && (w_wrap || (r_state == IDLE));
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_digit      <= 2'd0;
         r_an         <= 4'b1111;
         r_frame_done <= 1'b0;
         r_disp       <= 16'h0000;
         r_pend_data  <= 16'h0000;
         r_pending    <= 1'b0;
         r_ready      <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_digit      <= w_digit_nxt;
         r_an         <= w_an_nxt;
         r_frame_done <= w_wrap;
         if (w_commit) begin
            r_disp    <= r_pend_data;
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
         end
         if (w_capture) begin
            r_pend_data <= load_if.load_data;
            r_pending   <= 1'b1;
            r_ready     <= 1'b0;
         end
      end
   end

   assign load_if.load_ready = r_ready;
   assign disp_value         = r_disp;
   assign S0                 = r_digit[0];
   assign S1                 = r_digit[1];
   assign AN                 = r_an;
   assign frame_done         = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a
// timeline-based reference model of the scan controller.
module tb_ssd_scan_controller;
   localparam int DIV   = 8;
   localparam int BLK   = 2;
   localparam int P     = DIV + BLK;
   localparam int FRAME = 4 * P;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] disp_value;
   logic        S0, S1;
   logic [3:0]  AN;
   logic        frame_done;

   ssd_scan_controller_if u_if ();

   ssd_scan_controller #(.DIV(DIV), .BLANK_CYCLES(BLK), .CNT_W(16)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load_if    (u_if),
      .disp_value (disp_value),
      .S0         (S0),
      .S1         (S1),
      .AN         (AN),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference: m_t counts cycles since scanning started (-1 = idle).
   int          m_t = -1;
   logic [15:0] m_disp = '0;
   logic [15:0] m_pend_data = '0;
   bit          m_pend = 0;
   bit          m_fd = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_an();
      logic [3:0] one;
      int         d;
      one = 4'b0001;
      if (m_t < 0 || (m_t % P) < BLK) return 4'b1111;
      d = (m_t / P) % 4;
      return ~(one << d);
   endfunction

   function automatic logic [1:0] exp_sel();
      if (m_t < 0) return 2'd0;
      return 2'((m_t / P) % 4);
   endfunction

   task automatic model_step();
      bit wrap, commit, capture;
      if (reset) begin
         m_t = -1; m_disp = '0; m_pend = 0; m_fd = 0;
         return;
      end
      wrap    = (m_t >= 0) && enable && (((m_t + 1) % FRAME) == 0);
      commit  = m_pend && ((m_t < 0) || wrap);
      capture = u_if.load_valid && !m_pend;
      m_fd    = wrap;
      m_t     = enable ? m_t + 1 : -1;
      if (commit) begin
         m_disp = m_pend_data;
         m_pend = 0;
      end
      if (capture) begin
         m_pend_data = u_if.load_data;
         m_pend      = 1;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      check("an",    {28'd0, AN},          {28'd0, exp_an()});
      check("sel",   {30'd0, S1, S0},      {30'd0, exp_sel()});
      check("disp",  {16'd0, disp_value},  {16'd0, m_disp});
      check("ready", {31'd0, u_if.load_ready}, {31'd0, !m_pend});
      check("fdone", {31'd0, frame_done},  {31'd0, m_fd});
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      u_if.load_valid = 1'b0;
      u_if.load_data = '0;
      repeat (3) cycle();
      reset = 1'b0;

      // Plain scanning through the first frame boundary.
      enable = 1'b1;
      repeat (FRAME + 5) cycle();

      // Load BEEF during SHOW of digit 1.
      for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != (P + BLK + 3); i++) cycle();
      check("reach_digit1", {31'd0, (m_t % FRAME) == (P + BLK + 3)}, 32'd1);
      u_if.load_valid = 1'b1;
      u_if.load_data  = 16'hBEEF;
      cycle();
      u_if.load_valid = 1'b0;
      check("beef_held", {16'd0, disp_value}, 32'h0);
      for (int i = 0; i < 2 * FRAME && !m_fd; i++) cycle();
      check("beef_commit", {16'd0, disp_value}, 32'hBEEF);
      check("beef_ready", {31'd0, u_if.load_ready}, 32'd1);

      // Hold 1234 valid while another value is pending.
      u_if.load_valid = 1'b1;
      u_if.load_data  = 16'h1111;
      cycle();
      u_if.load_data  = 16'h1234;
      for (int i = 0; i < 2 * FRAME && !(m_pend && m_pend_data == 16'h1234); i++) cycle();
      u_if.load_valid = 1'b0;
      check("cap_1234", {31'd0, m_pend && m_pend_data == 16'h1234}, 32'd1);
      for (int i = 0; i < 2 * FRAME && !m_fd; i++) cycle();
      check("commit_1234", {16'd0, disp_value}, 32'h1234);

      // Idle load commits the next cycle.
      enable = 1'b0;
      repeat (2) cycle();
      u_if.load_valid = 1'b1;
      u_if.load_data  = 16'hA5A5;
      cycle();
      u_if.load_valid = 1'b0;
      check("a5_pend", {31'd0, u_if.load_ready}, 32'd0);
      cycle();
      check("a5_commit", {16'd0, disp_value}, 32'hA5A5);
      repeat (3) cycle();

      // Drop enable during SHOW of digit 2, then restart.
      enable = 1'b1;
      for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != (2 * P + BLK + 2); i++) cycle();
      enable = 1'b0;
      cycle();
      check("dis_an", {28'd0, AN}, 32'hF);
      check("dis_sel", {30'd0, S1, S0}, 32'd0);
      cycle();
      enable = 1'b1;
      repeat (2 * P) cycle();

      // Reset during SHOW of digit 3 with a value pending.
      for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != BLK; i++) cycle();
      u_if.load_valid = 1'b1;
      u_if.load_data  = 16'h7777;
      cycle();
      u_if.load_valid = 1'b0;
      for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != (3 * P + BLK + 1); i++) cycle();
      check("pend_before_rst", {31'd0, u_if.load_ready}, 32'd0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rst_disp", {16'd0, disp_value}, 32'h0);
      check("rst_ready", {31'd0, u_if.load_ready}, 32'd1);
      repeat (3) cycle();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         reset           = ($urandom_range(0, 199) == 0);
         enable          = ($urandom_range(0, 49) != 0);
         u_if.load_valid = ($urandom_range(0, 3) == 0);
         u_if.load_data  = 16'($urandom);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
- Time-multiplexed scan sequencer for the 4-digit seven-segment display path.
- Drives the 2-bit digit select (S1,S0) into the 4:1 nibble mux and the active-low digit anodes.
- Holds the 16-bit displayed value, one nibble per digit.
- Accepts new values through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new nibbles (no tearing).

Parameters:
- DIV, 50000, SHOW duration per digit in clk cycles (≥2); 1 kHz digit rate at 50 MHz.
- BLANK_CYCLES, 64, anti-ghosting blank interval per digit in clk cycles (≥1, < DIV).
- CNT_W, 16, width of the internal cycle counter; must hold max(DIV, BLANK_CYCLES)-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scan enable; 0 forces IDLE with display dark.
- load_valid  input  1  new display value offered.
- load_data  input  16  value; [3:0] = digit 0 … [15:12] = digit 3.
- load_ready  output  1  1 = no commit pending, so a value can be accepted.
- disp_value  output  16  committed value; feeds the mux nibble inputs W/X/Y/Z of digits 0..3.
- S0  output  1  digit select bit 0.
- S1  output  1  digit select bit 1.
- AN  output  4  active-low anode enables; AN[k]=0 lights digit k.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- All outputs are registered. Reset has priority over every other input.
- Reset values: state=IDLE, digit=0, {S1,S0}=00, AN=4'b1111, disp_value=0, pending=0, load_ready=1, frame_done=0, cnt=0.
- FSM states are IDLE, BLANK and SHOW.
- IDLE:
  - AN=1111 and digit=0.
  - If enable=1, go to BLANK next cycle with cnt=0.
- BLANK:
  - AN=1111; {S1,S0}=digit.
  - cnt increments each cycle.
  - When cnt==BLANK_CYCLES-1, go to SHOW with cnt=0. BLANK therefore lasts exactly BLANK_CYCLES cycles.
- SHOW:
  - AN has bit [digit] low and all other bits high; {S1,S0}=digit.
  - When cnt==DIV-1: digit=(digit+1) mod 4, go to BLANK with cnt=0. SHOW therefore lasts exactly DIV cycles.
- Timing:
  - Digit period = BLANK_CYCLES+DIV.
  - Frame = 4×(BLANK_CYCLES+DIV).
  - Select changes only on the SHOW→BLANK transition, so it is stable for the whole SHOW window.
- enable=0 in BLANK or SHOW: next cycle is IDLE with AN=1111, digit=0, cnt=0. This takes effect mid-digit; no partial-frame completion.
- Handshake:
  - A transfer occurs on a cycle with load_valid=1 and load_ready=1.
  - load_data is captured into the pending register, pending←1, and load_ready goes 0 next cycle.
  - load_valid while load_ready=0 is ignored; the producer must hold it.
- Commit:
  - The pending value is copied to disp_value and pending←0 (load_ready←1) at a frame boundary.
  - A frame boundary is the SHOW→BLANK transition where digit wraps 3→0.
  - frame_done=1 on the first cycle of the new frame, the same cycle the new disp_value appears.
- Commit in IDLE: a pending value commits on the cycle after capture, so latency is 1 cycle. frame_done stays 0 in IDLE.
- Capture and commit can never occur in the same cycle, because ready=0 whenever pending=1.
- Reset mid-frame discards any pending value and returns all outputs to their reset values on the next edge.

Test Plan:
- Reset, then enable=1 with DIV=8, BLANK_CYCLES=2.
  - Expect AN=1111 for 2 cycles, then 1110 for 8, 1111 for 2, 1101 for 8, and so on through 0111.
  - {S1,S0} must step 00→01→10→11→00.
  - First frame_done comes 40 cycles after the first BLANK cycle.
- Scanning, load 16'hBEEF mid-digit 1.
  - load_ready drops the next cycle; disp_value stays 0 until the wrap.
  - At the wrap, disp_value=BEEF with frame_done=1, and load_ready returns to 1 the same cycle.
- While pending, drive load_valid with 16'h1234 continuously.
  - Not accepted until load_ready=1; then captured and committed at the following frame boundary.
- enable=0, load 16'hA5A5.
  - load_ready=0 for exactly 1 cycle; disp_value=A5A5 the cycle after acceptance; AN=1111 throughout; no frame_done.
- Deassert enable during SHOW of digit 2.
  - Next cycle AN=1111 and {S1,S0}=00.
  - Re-enable: scanning restarts at digit 0 with a full BLANK interval.
- Assert reset during SHOW of digit 3 with a value pending.
  - Next cycle all outputs equal their reset values; disp_value=0; pending value lost.
